// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and default constants for the stopwatch controller, counter and display.
package stopwatch_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PRESET = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_ADJ_S  = 3'd3,
    ST_ADJ_M  = 3'd4
  } state_e;

  localparam int unsigned DEF_TICK_DIV   = 100_000_000;
  localparam int unsigned DEF_DB_CYCLES  = 1_000_000;
  localparam int unsigned DEF_REPEAT_DLY = 50_000_000;
  localparam int unsigned DEF_REPEAT_DIV = 25_000_000;

  localparam int unsigned PRESET_SEC = 55;
  localparam int unsigned PRESET_MIN = 59;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control strobes and status from the stopwatch controller to the time counter / display.
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic               tick_o;
  logic               preset_o;
  logic               inc_sec_o;
  logic               inc_min_o;
  logic [STATE_W-1:0] state_o;
  logic               blink_o;

  modport master (
    output tick_o, preset_o, inc_sec_o, inc_min_o, state_o, blink_o
  );

  modport slave (
    input tick_o, preset_o, inc_sec_o, inc_min_o, state_o, blink_o
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
module stopwatch_ctrl_btn_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned         CNT_W    = cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Level follows the sample only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounced level, its counter and the rise pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust sequencer: FSM, 1 s prescaler, inc auto-repeat and adjust-field blink.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_DIV = DEF_REPEAT_DIV
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             pause_i,
  input  logic             sw0,
  input  logic             sw1,
  input  logic             inc_btn_i,
  stopwatch_ctrl_if.master bus
);

  localparam int unsigned PRE_W    = cnt_w(TICK_DIV);
  localparam int unsigned BLK_HALF = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
  localparam int unsigned BLK_W    = cnt_w(BLK_HALF);
  localparam int unsigned REP_MAX  = (REPEAT_DLY > REPEAT_DIV) ? REPEAT_DLY : REPEAT_DIV;
  localparam int unsigned REP_W    = cnt_w(REP_MAX);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLK_HALF - 1);
  localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DLY - 1);
  localparam logic [REP_W-1:0] DIV_LAST = REP_W'(REPEAT_DIV - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             fast_q, fast_d;
  logic             armed_q, armed_d;
  logic [BLK_W-1:0] bcnt_q, bcnt_d;
  logic             blvl_q, blvl_d;
  logic             blink_q, blink_d;
  logic             inc_sec_q, inc_sec_d;
  logic             inc_min_q, inc_min_d;
  logic             fire_c;
  logic             db_level, db_rise;
  logic             run_stay, adj_stay, adj_next;
  logic [REP_W-1:0] rep_last;

  stopwatch_ctrl_btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rstn),
    .btn_i   (inc_btn_i),
    .level_o (db_level),
    .rise_o  (db_rise)
  );

  // Mode FSM next state; clear wins over everything.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = ST_PRESET;
    end else begin
      unique case (state_q)
        ST_PRESET: state_d = pause_i ? ST_PAUSE : ST_RUN;
        ST_RUN:    if (pause_i) state_d = ST_PAUSE;
        ST_PAUSE: begin
          if (!pause_i)  state_d = ST_RUN;
          else if (!sw0) state_d = ST_ADJ_S;
          else if (!sw1) state_d = ST_ADJ_M;
        end
        ST_ADJ_S:  if (sw0 || !pause_i) state_d = ST_PAUSE;
        ST_ADJ_M:  if (sw1 || !pause_i || !sw0) state_d = ST_PAUSE;
        default:   state_d = ST_PRESET;
      endcase
    end
  end

  assign run_stay = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign adj_next = (state_d == ST_ADJ_S) || (state_d == ST_ADJ_M);
  assign adj_stay = adj_next && (state_d == state_q);
  assign rep_last = fast_q ? DIV_LAST : DLY_LAST;

  // Prescaler, repeat timer, blink timer and strobe generation.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    rep_d   = rep_q;
    fast_d  = fast_q;
    armed_d = armed_q;
    fire_c  = 1'b0;
    bcnt_d  = '0;
    blvl_d  = 1'b1;

    // Advance only across RUN->RUN edges so a tick always lands inside RUN.
    if (state_q == ST_PRESET) begin
      presc_d = '0;
    end else if (run_stay) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end

    // First strobe on the debounced rise, then delay, then fixed-rate repeats.
    if (!(adj_stay && db_level)) begin
      armed_d = 1'b0;
      fast_d  = 1'b0;
      rep_d   = '0;
    end else if (db_rise) begin
      armed_d = 1'b1;
      fast_d  = 1'b0;
      rep_d   = '0;
      fire_c  = 1'b1;
    end else if (armed_q) begin
      if (rep_q == rep_last) begin
        rep_d  = '0;
        fast_d = 1'b1;
        fire_c = 1'b1;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end

    // Blink restarts visible on each ADJ entry, steady elsewhere.
    if (adj_stay) begin
      blvl_d = blvl_q;
      if (bcnt_q == BLK_LAST) begin
        blvl_d = ~blvl_q;
      end else begin
        bcnt_d = bcnt_q + BLK_W'(1);
      end
    end
  end

  assign inc_sec_d = fire_c && (state_q == ST_ADJ_S);
  assign inc_min_d = fire_c && (state_q == ST_ADJ_M);
  assign blink_d   = blvl_d | fire_c;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q   <= ST_PRESET;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      rep_q     <= '0;
      fast_q    <= 1'b0;
      armed_q   <= 1'b0;
      bcnt_q    <= '0;
      blvl_q    <= 1'b1;
      blink_q   <= 1'b1;
      inc_sec_q <= 1'b0;
      inc_min_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      rep_q     <= rep_d;
      fast_q    <= fast_d;
      armed_q   <= armed_d;
      bcnt_q    <= bcnt_d;
      blvl_q    <= blvl_d;
      blink_q   <= blink_d;
      inc_sec_q <= inc_sec_d;
      inc_min_q <= inc_min_d;
    end
  end

  assign bus.tick_o    = tick_q;
  assign bus.preset_o  = (state_q == ST_PRESET);
  assign bus.inc_sec_o = inc_sec_q;
  assign bus.inc_min_o = inc_min_q;
  assign bus.state_o   = state_q;
  assign bus.blink_o   = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed + randomized bench for stopwatch_ctrl against a time-based reference model.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  localparam int TICK_DIV   = 10;
  localparam int DB_CYCLES  = 4;
  localparam int REPEAT_DLY = 20;
  localparam int REPEAT_DIV = 5;
  localparam int HALF       = TICK_DIV / 2;

  logic clk = 1'b0;
  logic rstn;
  logic clr, pause, sw0, sw1, btn;

  int n_vec = 0;
  int n_err = 0;

  stopwatch_ctrl_if u_if ();

  stopwatch_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DB_CYCLES  (DB_CYCLES),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_DIV (REPEAT_DIV)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (clr),
    .pause_i   (pause),
    .sw0       (sw0),
    .sw1       (sw1),
    .inc_btn_i (btn),
    .bus       (u_if)
  );

  always #5 clk = ~clk;

  // Reference model: absolute-time view of the controller's rules.
  int  m_state;
  int  run_steps;
  bit  pipe[$];
  bit  hist[$];
  bit  m_level, m_level_prev;
  bit  armed;
  int  t0;
  int  adj_entry;
  int  cyc_n;
  int  e_state;
  bit  e_tick, e_sec, e_min, e_blink;

  function automatic int fsm_next(input int st);
    if (clr) return 0;
    case (st)
      0: return pause ? 2 : 1;
      1: return pause ? 2 : 1;
      2: return !pause ? 1 : (!sw0 ? 3 : (!sw1 ? 4 : 2));
      3: return (sw0 || !pause) ? 2 : 3;
      4: return (sw1 || !pause || !sw0) ? 2 : 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; run_steps = 0;
    pipe = '{1'b0, 1'b0};
    hist.delete();
    m_level = 1'b0; m_level_prev = 1'b0;
    armed = 1'b0; t0 = 0; adj_entry = 0; cyc_n = 0;
    e_state = 0; e_tick = 1'b0; e_sec = 1'b0; e_min = 1'b0; e_blink = 1'b1;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    int ns, d;
    bit in_adj, ok, fire, rise_c, samp, all_diff;
    ns     = fsm_next(m_state);
    in_adj = (m_state == 3) || (m_state == 4);

    e_tick = 1'b0;
    if (m_state == 0) run_steps = 0;
    else if (m_state == 1 && ns == 1) begin
      run_steps++;
      e_tick = (run_steps % TICK_DIV) == 0;
    end

    rise_c = m_level && !m_level_prev;
    ok     = in_adj && (ns == m_state) && m_level;
    fire   = 1'b0;
    if (!ok) armed = 1'b0;
    else if (rise_c) begin
      armed = 1'b1; t0 = cyc_n + 1; fire = 1'b1;
    end else if (armed) begin
      d    = cyc_n + 1 - t0;
      fire = (d >= REPEAT_DLY) && (((d - REPEAT_DLY) % REPEAT_DIV) == 0);
    end
    e_sec = fire && (m_state == 3);
    e_min = fire && (m_state == 4);

    if (ns == 3 || ns == 4) begin
      if (ns != m_state) adj_entry = cyc_n + 1;
      e_blink = ((((cyc_n + 1 - adj_entry) / HALF) % 2) == 0) || fire;
    end else begin
      e_blink = 1'b1;
    end

    samp = pipe.pop_front();
    pipe.push_back(btn);
    hist.push_back(samp);
    if (hist.size() > DB_CYCLES) void'(hist.pop_front());
    m_level_prev = m_level;
    if (hist.size() == DB_CYCLES) begin
      all_diff = 1'b1;
      foreach (hist[i]) if (hist[i] == m_level) all_diff = 1'b0;
      if (all_diff) m_level = !m_level;
    end

    m_state = ns;
    e_state = ns;
    cyc_n++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic check_outputs();
    int s;
    chk("state",   8'(u_if.state_o),   8'(e_state));
    chk("preset",  8'(u_if.preset_o),  8'(e_state == 0));
    chk("tick",    8'(u_if.tick_o),    8'(e_tick));
    chk("inc_sec", 8'(u_if.inc_sec_o), 8'(e_sec));
    chk("inc_min", 8'(u_if.inc_min_o), 8'(e_min));
    chk("blink",   8'(u_if.blink_o),   8'(e_blink));
    s = int'(u_if.tick_o) + int'(u_if.inc_sec_o) + int'(u_if.inc_min_o) + int'(u_if.preset_o);
    chk("excl",    8'(s <= 1),         8'd1);
  endtask

  task automatic cyc(input bit c, input bit p, input bit a, input bit b, input bit k);
    clr = c; pause = p; sw0 = a; sw1 = b; btn = k;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n, input bit c, input bit p, input bit a, input bit b, input bit k);
    repeat (n) cyc(c, p, a, b, k);
  endtask

  initial begin
    clr = 1'b1; pause = 1'b0; sw0 = 1'b1; sw1 = 1'b1; btn = 1'b0;
    rstn = 1'b1;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b0;

    // Hold clear, then run and collect ticks.
    run(3, 1, 0, 1, 1, 0);
    run(35, 0, 0, 1, 1, 0);

    // Asynchronous reset asserted mid-cycle while running.
    #3;
    rstn = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    #2;
    rstn = 1'b0;
    run(4, 1, 0, 1, 1, 0);

    // Run, pause for 100 cycles, resume keeping the fraction.
    run(26, 0, 0, 1, 1, 0);
    run(100, 0, 1, 1, 1, 0);
    run(25, 0, 0, 1, 1, 0);

    // Seconds adjust: clean press, then short bounces.
    run(3, 0, 1, 1, 1, 0);
    run(3, 0, 1, 0, 1, 0);
    run(10, 0, 1, 0, 1, 1);
    run(12, 0, 1, 0, 1, 0);
    run(2, 0, 1, 0, 1, 1);
    run(2, 0, 1, 0, 1, 0);
    run(3, 0, 1, 0, 1, 1);
    run(2, 0, 1, 0, 1, 0);
    run(10, 0, 1, 0, 1, 0);

    // Minutes adjust: long hold with auto-repeat, then release.
    run(3, 0, 1, 1, 0, 0);
    run(60, 0, 1, 1, 0, 1);
    run(30, 0, 1, 1, 0, 0);

    // Both selects low picks seconds; press while running is ignored.
    run(2, 0, 1, 1, 1, 0);
    run(6, 0, 1, 0, 0, 0);
    run(3, 0, 0, 1, 1, 0);
    run(12, 0, 0, 1, 1, 1);
    run(10, 0, 0, 1, 1, 0);

    // Clear while holding the button in minutes adjust.
    run(2, 0, 1, 1, 0, 0);
    run(24, 0, 1, 1, 0, 1);
    run(3, 1, 1, 1, 0, 1);
    run(10, 0, 1, 1, 0, 0);

    // Randomized mode/switch/button activity.
    for (int s = 0; s < 150; s++) begin
      bit c, p, a, b;
      int nsub;
      c = ($urandom_range(0, 15) == 0);
      p = ($urandom_range(0, 3) != 0);
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      nsub = $urandom_range(1, 4);
      for (int j = 0; j < nsub; j++) begin
        bit k;
        int len;
        k   = 1'($urandom_range(0, 1));
        len = c ? $urandom_range(1, 3)
                : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45));
        run(len, c, p, a, b, k);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
